// File: rtl/block_sequencer.sv
// Operand register bank and start/ready handshake controller for the processing block.
// Latches operands, issues a one-cycle start, waits for ready with a timeout, captures result.
module block_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] wr_data,
  input  logic [3:0] wr_sel,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] pe_in1,
  output logic [3:0] pe_in2,
  output logic [3:0] pe_in3,
  output logic [3:0] pe_in4,
  output logic       pe_start,
  input  logic       pe_rdy,
  input  logic [3:0] pe_out,
  output logic [3:0] result,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // The counter reads TIMEOUT-1 during the last permitted WAIT cycle.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state_r;
  logic [7:0] wait_cnt_r;

  // Sequencer FSM, operand bank and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
      pe_in1     <= 4'd0;
      pe_in2     <= 4'd0;
      pe_in3     <= 4'd0;
      pe_in4     <= 4'd0;
      pe_start   <= 1'b0;
      result     <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      pe_start <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (wr_sel[0]) pe_in1 <= wr_data;
          if (wr_sel[1]) pe_in2 <= wr_data;
          if (wr_sel[2]) pe_in3 <= wr_data;
          if (wr_sel[3]) pe_in4 <= wr_data;
          if (start) begin
            state_r  <= ISSUE;
            pe_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt_r <= 8'd0;
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          // Abort beats ready; ready beats the final timeout cycle.
          if (abort) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (pe_rdy) begin
            result   <= pe_out;
            err      <= 1'b0;
            op_count <= op_count + 8'd1;
            state_r  <= FINISH;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else if (wait_cnt_r == LAST_WAIT) begin
            err     <= 1'b1;
            state_r <= FINISH;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_sequencer.sv
// Directed self-checking bench for block_sequencer; one task per scenario.
module tb_block_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] wr_data;
  logic [3:0] wr_sel;
  logic       start;
  logic       abort;
  logic [3:0] pe_in1, pe_in2, pe_in3, pe_in4;
  logic       pe_start;
  logic       pe_rdy;
  logic [3:0] pe_out;
  logic [3:0] result;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  block_sequencer #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_sel(wr_sel),
    .start(start), .abort(abort),
    .pe_in1(pe_in1), .pe_in2(pe_in2), .pe_in3(pe_in3), .pe_in4(pe_in4),
    .pe_start(pe_start), .pe_rdy(pe_rdy), .pe_out(pe_out),
    .result(result), .busy(busy), .done(done), .err(err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_data = 4'd0; wr_sel = 4'd0; start = 1'b0; abort = 1'b0;
    pe_rdy = 1'b0; pe_out = 4'd0;
    #12 rst_n = 1'b1;
    step();
    wr_sel = 4'hF; wr_data = 4'd7;
    step();
    wr_sel = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++;
    if ({busy, pe_in1} !== {1'b1, 4'd7}) begin
      n_fail++; $display("FAIL reset_pre_busy got busy=%0b in1=%0h want 1/7", busy, pe_in1);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pe_in1, pe_in2, pe_in3, pe_in4, result, op_count, pe_start, busy, done, err} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async got in=%0h%0h%0h%0h res=%0h cnt=%0d ps=%0b b=%0b d=%0b e=%0b want all 0",
               pe_in1, pe_in2, pe_in3, pe_in4, result, op_count, pe_start, busy, done, err);
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if ({busy, done, pe_start} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle got b/d/ps=%0b%0b%0b want 000", busy, done, pe_start);
    end
    wr_data = 4'd9; wr_sel = 4'b0101;
    step();
    wr_sel = 4'd0;
    n_checks++;
    if ({pe_in1, pe_in2, pe_in3, pe_in4} !== 16'h9090) begin
      n_fail++; $display("FAIL reset_write got %0h%0h%0h%0h want 9090", pe_in1, pe_in2, pe_in3, pe_in4);
    end
  endtask

  task automatic test_nominal();
    wr_data = 4'd1; wr_sel = 4'b0001; step();
    wr_data = 4'd2; wr_sel = 4'b0010; step();
    wr_data = 4'd3; wr_sel = 4'b0100; step();
    wr_data = 4'd4; wr_sel = 4'b1000; step();
    wr_sel = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({pe_start, busy, pe_in1, pe_in2, pe_in3, pe_in4} !== 18'b11_0001_0010_0011_0100) begin
      n_fail++; $display("FAIL nominal_issue got ps=%0b b=%0b in=%0h%0h%0h%0h want 1 1 1234",
                         pe_start, busy, pe_in1, pe_in2, pe_in3, pe_in4);
    end
    step();
    n_checks++;
    if ({pe_start, busy, done} !== 3'b010) begin
      n_fail++; $display("FAIL nominal_wait got ps/b/d=%0b%0b%0b want 010", pe_start, busy, done);
    end
    pe_rdy = 1'b1; pe_out = 4'hA;
    step();
    pe_rdy = 1'b0;
    n_checks++;
    if ({done, busy, result, op_count, err} !== {1'b1, 1'b0, 4'hA, 8'd1, 1'b0}) begin
      n_fail++; $display("FAIL nominal_done got d=%0b b=%0b res=%0h cnt=%0d e=%0b want 1 0 a 1 0",
                         done, busy, result, op_count, err);
    end
    step();
    n_checks++;
    if ({done, pe_start} !== 2'b00) begin
      n_fail++; $display("FAIL nominal_done_pulse got d=%0b ps=%0b want 0 0", done, pe_start);
    end
  endtask

  task automatic run_timeout(input string name, input logic [3:0] exp_res, input logic [7:0] exp_cnt);
    int early = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 14; i++) begin
      if (done !== 1'b0) early++;
      step();
    end
    if (done !== 1'b0) early++;
    n_checks++;
    if (early != 0) begin
      n_fail++; $display("FAIL %s_early_done got %0d early cycles want 0", name, early);
    end
    step();
    n_checks++;
    if ({done, err, result, op_count} !== {1'b1, 1'b1, exp_res, exp_cnt}) begin
      n_fail++; $display("FAIL %s_done got d=%0b e=%0b res=%0h cnt=%0d want 1 1 %0h %0d",
                         name, done, err, result, op_count, exp_res, exp_cnt);
    end
    step();
  endtask

  task automatic test_timeout();
    run_timeout("timeout", 4'hA, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    pe_rdy = 1'b1; pe_out = 4'h5;
    step();
    pe_rdy = 1'b0;
    n_checks++;
    if ({done, err, result, op_count} !== {1'b1, 1'b0, 4'h5, 8'd2}) begin
      n_fail++; $display("FAIL timeout_recover got d=%0b e=%0b res=%0h cnt=%0d want 1 0 5 2",
                         done, err, result, op_count);
    end
    step();
  endtask

  task automatic test_boundary();
    run_timeout("bound_pre", 4'h5, 8'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    pe_rdy = 1'b1; pe_out = 4'hC;
    step();
    pe_rdy = 1'b0;
    n_checks++;
    if ({done, err, result, op_count} !== {1'b1, 1'b0, 4'hC, 8'd3}) begin
      n_fail++; $display("FAIL bound_last_rdy got d=%0b e=%0b res=%0h cnt=%0d want 1 0 c 3",
                         done, err, result, op_count);
    end
    step();
    // abort and ready together in WAIT
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1; pe_rdy = 1'b1; pe_out = 4'hE;
    step();
    abort = 1'b0; pe_rdy = 1'b0;
    n_checks++;
    if ({busy, done, result, op_count, err} !== {1'b0, 1'b0, 4'hC, 8'd3, 1'b0}) begin
      n_fail++; $display("FAIL bound_abort got b=%0b d=%0b res=%0h cnt=%0d e=%0b want 0 0 c 3 0",
                         busy, done, result, op_count, err);
    end
    step();
    n_checks++;
    if ({done, busy, pe_start} !== 3'b000) begin
      n_fail++; $display("FAIL bound_abort_idle got d/b/ps=%0b%0b%0b want 000", done, busy, pe_start);
    end
    // abort during ISSUE
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    n_checks++;
    if ({done, busy, pe_start, op_count} !== {3'b000, 8'd3}) begin
      n_fail++; $display("FAIL bound_abort_issue got d/b/ps=%0b%0b%0b cnt=%0d want 000 3",
                         done, busy, pe_start, op_count);
    end
  endtask

  task automatic test_lockout();
    int issues = 0;
    start = 1'b1;
    step();
    if (pe_start === 1'b1) issues++;
    wr_sel = 4'hF; wr_data = 4'hF; start = 1'b0;
    step();
    if (pe_start === 1'b1) issues++;
    start = 1'b1; pe_rdy = 1'b1; pe_out = 4'h3;
    step();
    if (pe_start === 1'b1) issues++;
    pe_rdy = 1'b0;
    step();
    if (pe_start === 1'b1) issues++;
    start = 1'b0; wr_sel = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pe_start === 1'b1) issues++;
    end
    n_checks++;
    if (issues != 1) begin
      n_fail++; $display("FAIL lockout_issues got %0d want 1", issues);
    end
    n_checks++;
    if ({pe_in1, pe_in2, pe_in3, pe_in4, op_count} !== {16'h1234, 8'd4}) begin
      n_fail++; $display("FAIL lockout_operands got %0h%0h%0h%0h cnt=%0d want 1234 4",
                         pe_in1, pe_in2, pe_in3, pe_in4, op_count);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    int issues = 0;
    start = 1'b1; pe_rdy = 1'b1; pe_out = 4'h6;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (pe_start === 1'b1) begin
        issues++;
        if (first < 0) first = i; else if (second < 0) second = i;
      end
      if (i == 6) start = 1'b0;
    end
    pe_rdy = 1'b0;
    n_checks++;
    if (issues != 2 || first != 1 || second != 5) begin
      n_fail++; $display("FAIL b2b_issue got n=%0d at %0d,%0d want 2 at 1,5", issues, first, second);
    end
    n_checks++;
    if ({op_count, result} !== {8'd6, 4'h6}) begin
      n_fail++; $display("FAIL b2b_count got cnt=%0d res=%0h want 6 6", op_count, result);
    end
  endtask

  task automatic test_wrap();
    int dones = 0;
    step();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    start = 1'b1; pe_rdy = 1'b1; pe_out = 4'h1;
    for (int i = 0; i < 1100 && dones < 256; i++) begin
      step();
      if (done === 1'b1) begin
        dones++;
        if (dones == 255) begin
          n_checks++;
          if (op_count !== 8'd255) begin
            n_fail++; $display("FAIL wrap_255 got %0d want 255", op_count);
          end
        end
        if (dones == 256) begin
          start = 1'b0;
          n_checks++;
          if (op_count !== 8'd0) begin
            n_fail++; $display("FAIL wrap_zero got %0d want 0", op_count);
          end
        end
      end
    end
    start = 1'b0; pe_rdy = 1'b0;
    n_checks++;
    if (dones != 256) begin
      n_fail++; $display("FAIL wrap_budget got %0d done pulses want 256", dones);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_boundary();
    test_lockout();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
